// File: rtl/led_blink_driver_pkg.sv
// Shared types and constants for the LED blink driver.
// Holds the FSM state encoding, the 50 MHz prescaler constant and the blink-count helper.
package led_blink_driver_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [15:0] CNT_1MS_50M = 16'd49_999;

    // A requested count of zero still produces one visible blink.
    function automatic logic [3:0] eff_blinks(input logic [3:0] num);
        return (num == 4'd0) ? 4'd1 : num;
    endfunction

endpackage

// File: rtl/led_blink_driver_ms_tick_gen.sv
// 1 ms prescaler: counts 0..CNT_LAST and flags the last count with a one-cycle tick.
// The synchronous clr lets the FSM restart a phase at a known count.
module led_blink_driver_ms_tick_gen
    import led_blink_driver_pkg::*;
#(
    parameter logic [15:0] CNT_LAST = CNT_1MS_50M
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (clr || (cnt_q >= CNT_LAST)) begin
            cnt_d = 16'd0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/led_blink_driver.sv
// Turns one-cycle request pulses into sequences of on/off LED blinks.
// Requests arriving mid-sequence are queued and replayed back to back.
module led_blink_driver
    import led_blink_driver_pkg::*;
#(
    parameter logic [15:0] CNT_1MS        = CNT_1MS_50M,
    parameter logic [9:0]  ON_MS          = 10'd200,
    parameter logic [9:0]  OFF_MS         = 10'd200,
    parameter logic [1:0]  PEND_MAX       = 2'd3,
    parameter logic        LED_ACTIVE_LOW = 1'b0
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       trig,
    input  logic [3:0] blink_num,
    output logic       led_out,
    output logic       busy,
    output logic       done,
    output logic       ovf
);

    state_t      state_q, state_d;
    logic [9:0]  ms_q, ms_d;
    logic [3:0]  blink_q, blink_d;
    logic [1:0]  pend_q, pend_d;
    logic        led_q, led_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;
    logic        clr;
    logic        tick;
    logic        phase_end;
    logic        seq_end;

    led_blink_driver_ms_tick_gen #(
        .CNT_LAST (CNT_1MS)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (clr),
        .tick      (tick)
    );

    assign phase_end = tick && (ms_q == ((state_q == ON) ? (ON_MS - 10'd1) : (OFF_MS - 10'd1)));
    // Edge E: the final OFF phase of the current sequence expires.
    assign seq_end   = (state_q == OFF) && phase_end && (blink_q <= 4'd1);

    always_comb begin
        state_d = state_q;
        blink_d = blink_q;
        pend_d  = pend_q;
        done_d  = 1'b0;
        ovf_d   = 1'b0;
        clr     = 1'b0;

        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (trig) begin
                    state_d = ON;
                    blink_d = eff_blinks(blink_num);
                end
            end
            ON: begin
                if (phase_end) begin
                    state_d = OFF;
                    clr     = 1'b1;
                end
            end
            OFF: begin
                if (phase_end) begin
                    clr = 1'b1;
                    if (blink_q > 4'd1) begin
                        state_d = ON;
                        blink_d = blink_q - 4'd1;
                    end else begin
                        done_d = 1'b1;
                        if ((pend_q != 2'd0) || trig) begin
                            state_d = ON;
                            blink_d = eff_blinks(blink_num);
                            // A coincident trig replaces the consumed entry.
                            if (!trig) begin
                                pend_d = pend_q - 2'd1;
                            end
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_q != IDLE) && !seq_end && trig) begin
            if (pend_q < PEND_MAX) begin
                pend_d = pend_q + 2'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_comb begin
        ms_d = ms_q;
        if (clr) begin
            ms_d = 10'd0;
        end else if (tick && (ms_q != 10'h3FF)) begin
            ms_d = ms_q + 10'd1;
        end
    end

    assign led_d  = (state_d == ON) ^ LED_ACTIVE_LOW;
    assign busy_d = (state_d != IDLE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            ms_q    <= 10'd0;
            blink_q <= 4'd0;
            pend_q  <= 2'd0;
            led_q   <= LED_ACTIVE_LOW;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ms_q    <= ms_d;
            blink_q <= blink_d;
            pend_q  <= pend_d;
            led_q   <= led_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    assign led_out = led_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_led_blink_driver.sv
// Drives led_blink_driver with directed and random requests and compares every cycle
// against a timeline model: sequence start time, blink count and a pending count.
module tb_led_blink_driver;

    localparam int CNT_LAST = 4;
    localparam int ON_MS_P  = 2;
    localparam int OFF_MS_P = 1;
    localparam int PMAX     = 3;
    localparam int ON_C     = ON_MS_P * (CNT_LAST + 1);
    localparam int OFF_C    = OFF_MS_P * (CNT_LAST + 1);
    localparam int BLINK_C  = ON_C + OFF_C;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       trig      = 1'b0;
    logic [3:0] blink_num = 4'd0;
    logic       led_out;
    logic       busy;
    logic       done;
    logic       ovf;

    int errors = 0;
    int checks = 0;
    int t      = 0;

    bit m_active = 1'b0;
    int m_s      = 0;
    int m_n      = 0;
    int m_p      = 0;
    bit m_led    = 1'b0;
    bit m_done   = 1'b0;
    bit m_ovf    = 1'b0;

    int done_seen = 0;
    int ovf_seen  = 0;

    led_blink_driver #(
        .CNT_1MS        (16'd4),
        .ON_MS          (10'd2),
        .OFF_MS         (10'd1),
        .PEND_MAX       (2'd3),
        .LED_ACTIVE_LOW (1'b0)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .trig      (trig),
        .blink_num (blink_num),
        .led_out   (led_out),
        .busy      (busy),
        .done      (done),
        .ovf       (ovf)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, t);
        end
    endtask

    function automatic int eff(input logic [3:0] b);
        return (b == 4'd0) ? 1 : int'(b);
    endfunction

    // Sequence of n blinks started at edge s ends at edge s + n*BLINK_C.
    function automatic bit next_is_end();
        return m_active && ((t - m_s) == m_n * BLINK_C);
    endfunction

    task automatic model_edge(input bit tr, input logic [3:0] b);
        m_done = 1'b0;
        m_ovf  = 1'b0;
        if (!m_active) begin
            if (tr) begin
                m_active = 1'b1;
                m_s      = t;
                m_n      = eff(b);
            end
        end else if ((t - m_s) == m_n * BLINK_C) begin
            m_done = 1'b1;
            if ((m_p > 0) || tr) begin
                if (!tr) m_p--;
                m_s = t;
                m_n = eff(b);
            end else begin
                m_active = 1'b0;
            end
        end else if (tr) begin
            if (m_p < PMAX) m_p++;
            else m_ovf = 1'b1;
        end
        m_led = m_active && (((t - m_s) % BLINK_C) < ON_C);
        t++;
    endtask

    task automatic model_clear();
        m_active = 1'b0;
        m_p      = 0;
        m_led    = 1'b0;
        m_done   = 1'b0;
        m_ovf    = 1'b0;
    endtask

    task automatic step(input bit tr, input logic [3:0] b);
        trig      = tr;
        blink_num = b;
        @(posedge sys_clk);
        model_edge(tr, b);
        #1;
        check_eq("led_out", led_out, m_led);
        check_eq("busy", busy, m_active);
        check_eq("done", done, m_done);
        check_eq("ovf", ovf, m_ovf);
        done_seen += int'(done);
        ovf_seen  += int'(ovf);
        trig = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        model_clear();
        #1;
        check_eq("rst_led_async", led_out, 0);
        check_eq("rst_busy_async", busy, 0);
        check_eq("rst_done_async", done, 0);
        check_eq("rst_ovf_async", ovf, 0);
        @(posedge sys_clk);
        t++;
        #1;
        sys_rst_n = 1'b1;
    endtask

    task automatic run_until_idle(input string tag, input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (!m_active) break;
            step(1'b0, 4'($urandom_range(0, 15)));
        end
        check_eq(tag, busy, 0);
    endtask

    initial begin
        bit found;

        repeat (3) @(posedge sys_clk);
        #1;
        do_reset();

        // Quiet after reset
        for (int i = 0; i < 50; i++) step(1'b0, 4'd0);

        // Three blinks; later blink_num changes must not matter
        done_seen = 0;
        step(1'b1, 4'd3);
        for (int i = 0; i < 55; i++) step(1'b0, 4'($urandom_range(0, 15)));
        check_eq("seq3_done_count", done_seen, 1);

        // blink_num 0 gives one blink
        done_seen = 0;
        step(1'b1, 4'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 4'd5);
        check_eq("zero_done_count", done_seen, 1);

        // Queue fill: 1 start + 3 queued + 2 dropped
        done_seen = 0;
        ovf_seen  = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 4'd1);
            step(1'b0, 4'd1);
        end
        run_until_idle("queue_idle", 200);
        check_eq("queue_done_count", done_seen, 4);
        check_eq("queue_ovf_count", ovf_seen, 2);

        // trig exactly at the end edge while one request is pending
        done_seen = 0;
        step(1'b1, 4'd1);
        step(1'b0, 4'd1);
        step(1'b1, 4'd1);
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (next_is_end()) begin
                found = 1'b1;
                break;
            end
            step(1'b0, 4'd1);
        end
        check_eq("edge_e_reached", found, 1);
        step(1'b1, 4'd1);
        run_until_idle("edge_e_idle", 200);
        check_eq("edge_e_done_count", done_seen, 3);

        // Reset mid-ON with two requests pending
        step(1'b1, 4'd2);
        step(1'b0, 4'd2);
        step(1'b1, 4'd2);
        step(1'b0, 4'd2);
        step(1'b1, 4'd2);
        step(1'b0, 4'd2);
        do_reset();
        done_seen = 0;
        for (int i = 0; i < 60; i++) step(1'b0, 4'd2);
        check_eq("post_reset_done_count", done_seen, 0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            step(($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)));
        end
        run_until_idle("random_idle", 1500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
